// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Data-port responder: sized RAM loads/stores plus MMIO console
//            FIFO, status flags and free-running cycle counter.
// Revision : 1.0
// ============================================================================
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        err_misalign
);

  localparam int            c_AW        = $clog2(DEPTH_WORDS);
  localparam int            c_FW        = $clog2(FIFO_DEPTH);
  localparam logic [32:0]   c_RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [c_FW:0] c_FULL      = (c_FW + 1)'(FIFO_DEPTH);

  logic [31:0]     r_mem [DEPTH_WORDS];
  logic [7:0]      r_buf [FIFO_DEPTH];
  logic [c_FW-1:0] r_rd;
  logic [c_FW-1:0] r_wr;
  logic [c_FW:0]   r_cnt;
  logic            r_ovf;
  logic            r_mis;
  logic [31:0]     r_cycle;

  logic            w_in_ram, w_in_mmio;
  logic            w_is_byte, w_is_half, w_is_word;
  logic            w_misalign;
  logic [c_AW-1:0] w_ram_idx;
  logic [31:0]     w_ram_word;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_ram_rd, w_mmio_rd;
  logic [3:0]      w_be;
  logic [31:0]     w_wlane;
  logic            w_ram_we, w_mmio_wr;
  logic            w_wr_tx, w_wr_stat, w_wr_cyc;
  logic            w_empty, w_full, w_pop, w_push, w_ovf_set;
  logic            w_mis_set, w_mis_clr, w_ovf_clr;

  assign w_in_ram   = {1'b0, Mem_WrAddr} < c_RAM_BYTES;
  assign w_in_mmio  = !w_in_ram && (Mem_WrAddr[31:4] == MMIO_BASE[31:4]);
  assign w_is_byte  = (Funct3 == 3'b000) || (Funct3 == 3'b100);
  assign w_is_half  = (Funct3 == 3'b001) || (Funct3 == 3'b101);
  assign w_is_word  = (Funct3 == 3'b010);
  assign w_misalign = (w_in_ram || w_in_mmio) &&
                      ((w_is_half && Mem_WrAddr[0]) ||
                       (w_is_word && (Mem_WrAddr[1:0] != 2'b00)));

  assign w_ram_idx  = Mem_WrAddr[c_AW+1:2];
  assign w_ram_word = r_mem[w_ram_idx];

  always_comb begin
    w_byte   = 8'h00;
    w_ram_rd = 32'h0;
    case (Mem_WrAddr[1:0])
      2'b00:   w_byte = w_ram_word[7:0];
      2'b01:   w_byte = w_ram_word[15:8];
      2'b10:   w_byte = w_ram_word[23:16];
      default: w_byte = w_ram_word[31:24];
    endcase
    w_half = Mem_WrAddr[1] ? w_ram_word[31:16] : w_ram_word[15:0];
    // Funct3[2] selects zero extension for the unsigned variants
    if (w_is_byte)
      w_ram_rd = {{24{~Funct3[2] & w_byte[7]}}, w_byte};
    else if (w_is_half)
      w_ram_rd = {{16{~Funct3[2] & w_half[15]}}, w_half};
    else if (w_is_word)
      w_ram_rd = w_ram_word;
  end

  always_comb begin
    w_mmio_rd = 32'h0;
    if (w_is_word) begin
      case (Mem_WrAddr[3:2])
        2'b01:   w_mmio_rd = {28'h0, r_mis, r_ovf, w_full, w_empty};
        2'b10:   w_mmio_rd = r_cycle;
        default: w_mmio_rd = 32'h0;
      endcase
    end
  end

  always_comb begin
    ReadData = 32'h0;
    if (!w_misalign) begin
      if (w_in_ram)
        ReadData = w_ram_rd;
      else if (w_in_mmio)
        ReadData = w_mmio_rd;
    end
  end

  always_comb begin
    w_be    = 4'b0000;
    w_wlane = Mem_WrData;
    if (w_is_byte) begin
      w_be    = 4'b0001 << Mem_WrAddr[1:0];
      w_wlane = {4{Mem_WrData[7:0]}};
    end else if (w_is_half) begin
      w_be    = Mem_WrAddr[1] ? 4'b1100 : 4'b0011;
      w_wlane = {2{Mem_WrData[15:0]}};
    end else if (w_is_word) begin
      w_be    = 4'b1111;
    end
  end

  assign w_ram_we  = MemWrite && w_in_ram && !w_misalign && !Funct3[2];
  assign w_mmio_wr = MemWrite && w_in_mmio && w_is_word && !w_misalign;
  assign w_wr_tx   = w_mmio_wr && (Mem_WrAddr[3:2] == 2'b00);
  assign w_wr_stat = w_mmio_wr && (Mem_WrAddr[3:2] == 2'b01);
  assign w_wr_cyc  = w_mmio_wr && (Mem_WrAddr[3:2] == 2'b10);

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_ram_we && w_be[i])
        r_mem[w_ram_idx][8*i +: 8] <= w_wlane[8*i +: 8];
    end
  end

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == c_FULL);
  assign w_pop     = !w_empty && tx_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
  assign w_push    = w_wr_tx && (!w_full || w_pop);
  assign w_ovf_set = w_wr_tx && w_full && !w_pop;
  assign tx_valid  = !w_empty;
  assign tx_data   = w_empty ? 8'h00 : r_buf[r_rd];

  always_ff @(posedge clk) begin
    if (w_push)
      r_buf[r_wr] <= Mem_WrData[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push)
        r_wr <= r_wr + 1'b1;
      if (w_pop)
        r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  assign w_mis_set = (MemWrite || MemRead) && w_misalign;
  assign w_mis_clr = w_wr_stat && Mem_WrData[3];
  assign w_ovf_clr = w_wr_stat && Mem_WrData[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf   <= 1'b0;
      r_mis   <= 1'b0;
      r_cycle <= 32'h0;
    end else begin
      r_ovf   <= w_ovf_set || (r_ovf && !w_ovf_clr);
      r_mis   <= w_mis_set || (r_mis && !w_mis_clr);
      r_cycle <= w_wr_cyc ? Mem_WrData : r_cycle + 32'd1;
    end
  end

  assign err_misalign = r_mis;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Vector table, directed multi-cycle sequences and randomized
//            traffic checked against a byte/queue-level reference model.
// Revision : 1.0
// ============================================================================
module tb_data_mem_responder;

  localparam int          DW   = 1024;
  localparam int          FD   = 8;
  localparam logic [31:0] TXA  = 32'hFFFF_0000;
  localparam logic [31:0] STA  = 32'hFFFF_0004;
  localparam logic [31:0] CYA  = 32'hFFFF_0008;
  localparam logic [31:0] IDLA = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite, MemRead, tx_ready;
  logic [2:0]  Funct3;
  logic [31:0] Mem_WrAddr, Mem_WrData, ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid, err_misalign;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DW), .FIFO_DEPTH(FD), .MMIO_BASE(32'hFFFF_0000)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .Funct3(Funct3), .Mem_WrAddr(Mem_WrAddr), .Mem_WrData(Mem_WrData),
    .ReadData(ReadData), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .err_misalign(err_misalign)
  );

  // Reference model: byte-addressed memory, a byte queue and plain flags
  logic [7:0]  m_mem [0:4095];
  logic [7:0]  m_q[$];
  logic        m_ovf, m_mis;
  logic [31:0] m_cyc;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic m_is_ram(input logic [31:0] a);
    return a < 32'(DW * 4);
  endfunction

  function automatic logic m_is_mmio(input logic [31:0] a);
    return !m_is_ram(a) && (a[31:4] == 28'hFFFF000);
  endfunction

  function automatic logic m_misal(input logic [2:0] f3, input logic [31:0] a);
    logic mapped = m_is_ram(a) || m_is_mmio(a);
    return mapped && (((f3[1:0] == 2'b01) && a[0]) || ((f3 == 3'b010) && (a[1:0] != 2'b00)));
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] f3, input logic [31:0] a);
    logic [11:0] ix = a[11:0];
    logic [7:0]  b;
    logic [15:0] h;
    if (m_misal(f3, a)) return 32'h0;
    if (m_is_ram(a)) begin
      case (f3)
        3'b000, 3'b100: begin
          b = m_mem[ix];
          return f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
        end
        3'b001, 3'b101: begin
          h = {m_mem[ix + 12'd1], m_mem[ix]};
          return f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
        end
        3'b010: return {m_mem[ix + 12'd3], m_mem[ix + 12'd2], m_mem[ix + 12'd1], m_mem[ix]};
        default: return 32'h0;
      endcase
    end
    if (m_is_mmio(a) && f3 == 3'b010) begin
      if (a[3:0] == 4'h4) return {28'h0, m_mis, m_ovf, m_q.size() == FD, m_q.size() == 0};
      if (a[3:0] == 4'h8) return m_cyc;
    end
    return 32'h0;
  endfunction

  task automatic model_edge();
    logic        mis, pop, push, oset, oclr, mclr;
    logic [31:0] ncyc;
    logic [11:0] ix;
    if (reset) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_mis = 1'b0;
      m_cyc = 32'h0;
      return;
    end
    mis  = m_misal(Funct3, Mem_WrAddr);
    pop  = (m_q.size() > 0) && tx_ready;
    push = 1'b0; oset = 1'b0; oclr = 1'b0; mclr = 1'b0;
    ncyc = m_cyc + 32'd1;
    ix   = Mem_WrAddr[11:0];
    if (MemWrite && !mis) begin
      if (m_is_ram(Mem_WrAddr) && !Funct3[2]) begin
        for (int k = 0; k < 4; k++) begin
          if (k < (1 << Funct3[1:0])) m_mem[ix + 12'(k)] = Mem_WrData[8*k +: 8];
        end
      end else if (m_is_mmio(Mem_WrAddr) && Funct3 == 3'b010) begin
        case (Mem_WrAddr[3:0])
          4'h0: if (m_q.size() < FD || pop) push = 1'b1; else oset = 1'b1;
          4'h4: begin oclr = Mem_WrData[2]; mclr = Mem_WrData[3]; end
          4'h8: ncyc = Mem_WrData;
          default: ;
        endcase
      end
    end
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(Mem_WrData[7:0]);
    m_ovf = oset || (m_ovf && !oclr);
    m_mis = ((MemWrite || MemRead) && mis) || (m_mis && !mclr);
    m_cyc = ncyc;
  endtask

  task automatic drive(input logic we, input logic rd, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic txr);
    MemWrite = we; MemRead = rd; Funct3 = f3;
    Mem_WrAddr = a; Mem_WrData = wd; tx_ready = txr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input logic txr);
    drive(1'b0, 1'b0, 3'b010, IDLA, 32'h0, txr);
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d, input logic txr);
    drive(1'b1, 1'b0, 3'b010, a, d, txr);
  endtask

  task automatic lw(input logic [31:0] a, input logic txr);
    drive(1'b0, 1'b1, 3'b010, a, 32'h0, txr);
  endtask

  typedef struct {
    logic        we;
    logic        rd;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  f3;
    logic [31:0] a;
    logic        we, rd;
    int          r;

    for (int i = 0; i < 4096; i++) m_mem[i] = 8'h00;
    m_ovf = 1'b0; m_mis = 1'b0; m_cyc = 32'h0;

    reset = 1'b1;
    @(negedge clk);
    idle(1'b0);
    tick();
    tick();
    reset = 1'b0;

    lw(CYA, 1'b0);
    check("rst_cycle", ReadData, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_err", {31'h0, err_misalign}, 32'h0);
    tick();
    lw(STA, 1'b0);
    check("rst_status", ReadData, 32'h1);
    tick();

    for (int i = 0; i < 64; i++) begin
      sw(32'(i * 4), 32'h0, 1'b0);
      tick();
    end

    tbl = '{
      '{1'b1, 1'b0, 3'b010, 32'h10, 32'h8000_00FF, 1'b0, 32'h0, "sw_10"},
      '{1'b1, 1'b0, 3'b000, 32'h11, 32'h0000_0080, 1'b0, 32'h0, "sb_11"},
      '{1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 1'b1, 32'h8000_80FF, "lw_10"},
      '{1'b0, 1'b1, 3'b000, 32'h11, 32'h0, 1'b1, 32'hFFFF_FF80, "lb_11"},
      '{1'b0, 1'b1, 3'b100, 32'h11, 32'h0, 1'b1, 32'h0000_0080, "lbu_11"},
      '{1'b0, 1'b1, 3'b001, 32'h12, 32'h0, 1'b1, 32'hFFFF_8000, "lh_12"},
      '{1'b0, 1'b1, 3'b101, 32'h12, 32'h0, 1'b1, 32'h0000_8000, "lhu_12"},
      '{1'b0, 1'b1, 3'b010, 32'h12, 32'h0, 1'b1, 32'h0, "lw_misaligned"},
      '{1'b0, 1'b1, 3'b010, STA, 32'h0, 1'b1, 32'h9, "status_mis_set"},
      '{1'b1, 1'b0, 3'b010, 32'h21, 32'hDEAD_BEEF, 1'b1, 32'h0, "sw_mis_read"},
      '{1'b0, 1'b1, 3'b010, 32'h20, 32'h0, 1'b1, 32'h0, "sw_mis_suppressed"},
      '{1'b1, 1'b0, 3'b001, 32'h22, 32'h1234_ABCD, 1'b0, 32'h0, "sh_22"},
      '{1'b0, 1'b1, 3'b010, 32'h20, 32'h0, 1'b1, 32'hABCD_0000, "sh_lane"},
      '{1'b1, 1'b0, 3'b010, STA, 32'h8, 1'b1, 32'h9, "status_w1c_old"},
      '{1'b0, 1'b1, 3'b010, STA, 32'h0, 1'b1, 32'h1, "status_mis_clear"},
      '{1'b0, 1'b1, 3'b010, 32'h1000_0000, 32'h0, 1'b1, 32'h0, "unmapped_read"},
      '{1'b0, 1'b1, 3'b000, STA, 32'h0, 1'b1, 32'h0, "mmio_byte_read"},
      '{1'b0, 1'b1, 3'b010, STA, 32'h0, 1'b1, 32'h1, "mmio_byte_no_flag"}
    };
    foreach (tbl[i]) begin
      drive(tbl[i].we, tbl[i].rd, tbl[i].f3, tbl[i].a, tbl[i].wd, 1'b0);
      if (tbl[i].chk) check(tbl[i].name, ReadData, tbl[i].exp);
      tick();
    end

    // FIFO fill past capacity, then drain
    for (int i = 0; i < 9; i++) begin
      sw(TXA, 32'h41 + 32'(i), 1'b0);
      tick();
    end
    lw(STA, 1'b0);
    check("fill_status", ReadData, 32'h6);
    check("fill_head", {24'h0, tx_data}, 32'h41);
    tick();
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      check("drain_valid", {31'h0, tx_valid}, 32'h1);
      check("drain_data", {24'h0, tx_data}, 32'h41 + 32'(i));
      tick();
    end
    lw(STA, 1'b1);
    check("drain_done_valid", {31'h0, tx_valid}, 32'h0);
    check("drain_status", ReadData, 32'h5);
    tick();
    sw(STA, 32'h4, 1'b0);
    tick();

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      sw(TXA, 32'h10 + 32'(i), 1'b0);
      tick();
    end
    sw(TXA, 32'h5A, 1'b1);
    check("pp_head", {24'h0, tx_data}, 32'h10);
    tick();
    lw(STA, 1'b0);
    check("pp_status", ReadData, 32'h2);
    tick();
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      check("pp_drain", {24'h0, tx_data}, (i < 7) ? 32'h11 + 32'(i) : 32'h5A);
      tick();
    end
    idle(1'b0);
    check("pp_empty", {31'h0, tx_valid}, 32'h0);

    // Counter write and wrap
    sw(CYA, 32'hFFFF_FFFE, 1'b0);
    tick();
    lw(CYA, 1'b0);
    check("cyc_written", ReadData, 32'hFFFF_FFFE);
    tick();
    check("cyc_max", ReadData, 32'hFFFF_FFFF);
    tick();
    check("cyc_wrap", ReadData, 32'h0);
    tick();

    // Reset in the middle of traffic
    sw(32'h40, 32'h1234_5678, 1'b0);
    tick();
    for (int i = 0; i < 9; i++) begin
      sw(TXA, 32'h61 + 32'(i), 1'b0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      tick();
    end
    drive(1'b0, 1'b1, 3'b010, 32'h42, 32'h0, 1'b0);
    tick();
    lw(STA, 1'b0);
    check("pre_rst_status", ReadData, 32'hC);
    tick();
    reset = 1'b1;
    sw(CYA, 32'h55, 1'b1);
    tick();
    reset = 1'b0;
    lw(CYA, 1'b0);
    check("mid_rst_cycle", ReadData, 32'h0);
    check("mid_rst_valid", {31'h0, tx_valid}, 32'h0);
    tick();
    lw(STA, 1'b0);
    check("mid_rst_status", ReadData, 32'h1);
    check("mid_rst_err", {31'h0, err_misalign}, 32'h0);
    tick();
    lw(32'h40, 1'b0);
    check("ram_kept", ReadData, 32'h1234_5678);
    tick();

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      r  = $urandom_range(0, 9);
      f3 = 3'b010; a = IDLA; we = 1'b0; rd = 1'b0;
      if (r <= 4) begin
        f3 = f3s[$urandom_range(0, 4)];
        a  = 32'($urandom_range(0, 255));
        we = f3[2] ? 1'b0 : 1'($urandom_range(0, 1));
        rd = !we && 1'($urandom_range(0, 1));
      end else if (r <= 7) begin
        f3 = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'b010;
        a  = 32'hFFFF_0000 | ((f3 == 3'b010 && $urandom_range(0, 5) != 0) ?
                              32'($urandom_range(0, 3) * 4) : 32'($urandom_range(0, 15)));
        we = 1'($urandom_range(0, 1));
        rd = !we;
      end else if (r == 8) begin
        a  = 32'h0001_0000 + 32'($urandom_range(0, 255));
        we = 1'($urandom_range(0, 1));
        rd = !we;
      end
      reset = ($urandom_range(0, 149) == 0);
      drive(we, rd, f3, a, $urandom, 1'($urandom_range(0, 1)));
      check("rnd_read", ReadData, m_read(f3, a));
      check("rnd_valid", {31'h0, tx_valid}, {31'h0, m_q.size() != 0});
      check("rnd_data", {24'h0, tx_data}, (m_q.size() != 0) ? {24'h0, m_q[0]} : 32'h0);
      check("rnd_err", {31'h0, err_misalign}, {31'h0, m_mis});
      tick();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
